tinker_operand_stage: RTL

//  Register-read/issue stage that sits directly upstream of alu_fpu in the Tinker core.
//  - Holds the 32x64 register file.
//  - Reads the source operands for each decoded instruction and selects R[rt] or the immediate.
//  - Presents a, b, op and is_float to alu_fpu from a one-entry output pipeline register.
//  - Accepts writeback from downstream and tracks pending writes with a per-register busy

---
 rtl/tinker_operand_stage.sv | 132 +++++++++++++
 1 files changed

// File: rtl/tinker_operand_stage.sv
// Register-read / issue stage feeding alu_fpu: 32x64 register file, busy scoreboard for
// RAW/WAW stalls, writeback bypass into operand capture, and a one-entry output register.
module tinker_operand_stage #(
    parameter int unsigned    NREGS      = 32,
    parameter int unsigned    XLEN       = 64,
    parameter logic [XLEN-1:0] STACK_INIT = 64'h80000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic [4:0]      in_rs,
    input  logic [4:0]      in_rt,
    input  logic [11:0]     in_imm,
    input  logic            in_use_imm,
    input  logic            in_wr_rd,
    input  logic [3:0]      in_op,
    input  logic            in_float,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [3:0]      out_op,
    output logic            out_float,
    output logic [4:0]      out_rd,
    output logic            out_wr_rd,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [NREGS-1:0] wb_mask, eff_busy;
    logic             hazard, issue;
    logic [XLEN-1:0]  rs_val, rt_val;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_a_q, out_a_d, out_b_q, out_b_d;
    logic [3:0]       out_op_q, out_op_d;
    logic             out_float_q, out_float_d;
    logic [4:0]       out_rd_q, out_rd_d;
    logic             out_wr_rd_q, out_wr_rd_d;

    // Hazard detection, handshake and bypassed operand read.
    always_comb begin
        wb_mask = '0;
        if (wb_valid) wb_mask[wb_rd] = 1'b1;
        // A writeback landing this cycle releases its register immediately.
        eff_busy = busy_q & ~wb_mask;
        hazard   = eff_busy[in_rs] | (!in_use_imm & eff_busy[in_rt]) | (in_wr_rd & eff_busy[in_rd]);
        in_ready = !hazard && (!out_valid_q || out_ready) && !flush && !reset;
        issue    = in_valid && in_ready;
        rs_val   = (wb_valid && wb_rd == in_rs) ? wb_data : regs_q[in_rs];
        rt_val   = (wb_valid && wb_rd == in_rt) ? wb_data : regs_q[in_rt];
    end

    // Register file next state: writeback only; flush keeps contents.
    always_comb begin
        for (int unsigned i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
        if (wb_valid) regs_d[wb_rd] = wb_data;
    end

    // Scoreboard next state: issue set wins over a same-cycle writeback clear.
    always_comb begin
        busy_d = busy_q & ~wb_mask;
        if (issue && in_wr_rd) busy_d[in_rd] = 1'b1;
        if (flush) busy_d = '0;
    end

    // Output register next state: load on issue, drop when consumed or flushed.
    always_comb begin
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_op_d    = out_op_q;
        out_float_d = out_float_q;
        out_rd_d    = out_rd_q;
        out_wr_rd_d = out_wr_rd_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (issue) begin
            out_valid_d = 1'b1;
            out_a_d     = rs_val;
            out_b_d     = in_use_imm ? {{(XLEN-12){1'b0}}, in_imm} : rt_val;
            out_op_d    = in_op;
            out_float_d = in_float;
            out_rd_d    = in_rd;
            out_wr_rd_d = in_wr_rd;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State update with dominant synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
            regs_q[NREGS-1] <= STACK_INIT;
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_op_q    <= '0;
            out_float_q <= 1'b0;
            out_rd_q    <= '0;
            out_wr_rd_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_op_q    <= out_op_d;
            out_float_q <= out_float_d;
            out_rd_q    <= out_rd_d;
            out_wr_rd_q <= out_wr_rd_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_op    = out_op_q;
    assign out_float = out_float_q;
    assign out_rd    = out_rd_q;
    assign out_wr_rd = out_wr_rd_q;

endmodule
